// File: rtl/bcd_to_binary_eight_bit_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Also holds the input legality check used when error checking is enabled.
package bcd_to_binary_eight_bit_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int         BIN_MAX       = 255;
    localparam logic [3:0] N_SHIFT       = 4'd8;
    localparam logic [3:0] BCD_ADJ       = 4'd3;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;

    // Non-decimal digits, or a value that does not fit in 8 bits (this includes hundreds==3).
    function automatic logic bcd_invalid(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        int value;
        value = 100 * int'(h) + 10 * int'(t) + int'(o);
        return (t > BCD_MAX_DIGIT) || (o > BCD_MAX_DIGIT) || (value > BIN_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double-dabble:
// a digit that became >= 8 after the right shift is reduced by 3.
module bcd_digit_adjust
    import bcd_to_binary_eight_bit_seq_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= ADJ_THRESH) ? (digit_in - BCD_ADJ) : digit_in;

endmodule

// File: rtl/bcd_to_binary_eight_bit_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble,
// one shift per clock) with a start/busy/done handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; out/error hold the last result
//   ST_SHIFT | converting, one shift+adjust per edge, busy=1
//   ST_DONE  | one-cycle done pulse; start here begins the next conversion
module bcd_to_binary_eight_bit_seq
    import bcd_to_binary_eight_bit_seq_pkg::*;
#(
    parameter bit ERR_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    state_t      state, state_next;
    logic [17:0] work;
    logic [17:0] shifted;
    logic [17:0] work_shift;
    logic [3:0]  count;
    logic [3:0]  tens_adj, ones_adj;
    logic        accept, reject, last_shift;

    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign reject     = accept && ERR_CHECK && bcd_invalid(hundreds, tens, ones);
    assign last_shift = (state == ST_SHIFT) && (count == (N_SHIFT - 4'd1));

    // Layout: [17:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary shifted in from the top.
    assign shifted = work >> 1;

    bcd_digit_adjust u_adj_tens (.digit_in(shifted[15:12]), .digit_out(tens_adj));
    bcd_digit_adjust u_adj_ones (.digit_in(shifted[11:8]),  .digit_out(ones_adj));

    assign work_shift = {shifted[17:16], tens_adj, ones_adj, shifted[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = reject ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_shift) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept) state_next = reject ? ST_DONE : ST_SHIFT;
                else        state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work  <= '0;
            count <= '0;
            out   <= '0;
            error <= 1'b0;
        end else if (accept) begin
            count <= '0;
            if (reject) begin
                out   <= '0;
                error <= 1'b1;
            end else begin
                work <= {hundreds, tens, ones, 8'b0};
            end
        end else if (state == ST_SHIFT) begin
            work  <= work_shift;
            count <= count + 4'd1;
            if (last_shift) begin
                out   <= work_shift[7:0];
                error <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_to_binary_eight_bit_seq.sv
// Directed bench for the sequential BCD-to-binary converter: reset, known
// conversions, rejected inputs, ignored starts, mid-run reset and a full sweep.
module tb_bcd_to_binary_eight_bit_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       error;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [7:0] exp;
    } vec_t;

    vec_t valid_vecs [5] = '{
        '{2'd2, 4'd5, 4'd5, 8'hFF},
        '{2'd1, 4'd2, 4'd8, 8'h80},
        '{2'd0, 4'd0, 4'd1, 8'h01},
        '{2'd0, 4'd9, 4'd9, 8'h63},
        '{2'd1, 4'd0, 4'd0, 8'h64}
    };

    vec_t invalid_vecs [5] = '{
        '{2'd0, 4'd10, 4'd0,  8'h00},
        '{2'd2, 4'd5,  4'd6,  8'h00},
        '{2'd3, 4'd0,  4'd0,  8'h00},
        '{2'd1, 4'd0,  4'd12, 8'h00},
        '{2'd2, 4'd6,  4'd0,  8'h00}
    };

    always #5 clk = ~clk;

    bcd_to_binary_eight_bit_seq #(.ERR_CHECK(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Accept one request, then wait (bounded) for done; lat counts cycles after the accept edge.
    task automatic run_conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                            output int lat, output int bcnt);
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        step;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            step;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        hundreds = 2'd2; tens = 4'd5; ones = 4'd5;
        step;
        step;
        vectors++; if (out !== 8'h00) begin miscompares++; $display("FAIL reset_out got=%h want=00", out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b want=0", error); end
        reset = 1'b0;
        start = 1'b0;
        step;
    endtask

    task automatic test_zero;
        int lat, bcnt;
        run_conv(2'd0, 4'd0, 4'd0, lat, bcnt);
        vectors++; if (lat != 8) begin miscompares++; $display("FAIL zero_latency got=%0d want=8", lat); end
        vectors++; if (bcnt != 8) begin miscompares++; $display("FAIL zero_busy_cycles got=%0d want=8", bcnt); end
        vectors++; if (out !== 8'h00 || error !== 1'b0) begin
            miscompares++; $display("FAIL zero_result got out=%h err=%b want out=00 err=0", out, error);
        end
        step;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL zero_done_pulse got done=%b busy=%b want done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_values;
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            run_conv(valid_vecs[i].h, valid_vecs[i].t, valid_vecs[i].o, lat, bcnt);
            vectors++; if (out !== valid_vecs[i].exp || error !== 1'b0 || lat != 8 || bcnt != 8) begin
                miscompares++;
                $display("FAIL value_%0d got out=%h err=%b lat=%0d busy=%0d want out=%h err=0 lat=8 busy=8",
                         i, out, error, lat, bcnt, valid_vecs[i].exp);
            end
            step;
            step;
            vectors++; if (out !== valid_vecs[i].exp || done !== 1'b0) begin
                miscompares++;
                $display("FAIL value_hold_%0d got out=%h done=%b want out=%h done=0", i, out, done, valid_vecs[i].exp);
            end
        end
    endtask

    task automatic test_invalid;
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            run_conv(2'd1, 4'd2, 4'd8, lat, bcnt);
            vectors++; if (out !== 8'h80) begin
                miscompares++; $display("FAIL invalid_pre_%0d got out=%h want 80", i, out);
            end
            run_conv(invalid_vecs[i].h, invalid_vecs[i].t, invalid_vecs[i].o, lat, bcnt);
            vectors++; if (lat != 0 || bcnt != 0 || error !== 1'b1 || out !== 8'h00) begin
                miscompares++;
                $display("FAIL invalid_%0d got lat=%0d busy=%0d err=%b out=%h want lat=0 busy=0 err=1 out=00",
                         i, lat, bcnt, error, out);
            end
        end
        step;
        vectors++; if (done !== 1'b0 || error !== 1'b1) begin
            miscompares++; $display("FAIL invalid_hold got done=%b err=%b want done=0 err=1", done, error);
        end
    endtask

    task automatic test_start_during_shift;
        int lat;
        hundreds = 2'd1; tens = 4'd2; ones = 4'd8;
        start = 1'b1;
        step;
        start = 1'b0;
        hundreds = 2'd0; tens = 4'd0; ones = 4'd1;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            start = (lat == 3);
            step;
            lat++;
        end
        start = 1'b0;
        vectors++; if (lat != 8 || out !== 8'h80 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_shift got lat=%0d out=%h err=%b want lat=8 out=80 err=0", lat, out, error);
        end
        step;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL start_in_shift_queued got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt;
        logic saw_done;
        hundreds = 2'd2; tens = 4'd5; ones = 4'd5;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b done=%b out=%h err=%b want 0 0 00 0", busy, done, out, error);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            step;
        end
        vectors++; if (saw_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_activity got=1 want=0");
        end
        run_conv(2'd0, 4'd0, 4'd1, lat, bcnt);
        vectors++; if (lat != 8 || out !== 8'h01 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_recover got lat=%0d out=%h err=%b want lat=8 out=01 err=0", lat, out, error);
        end
        step;
    endtask

    task automatic test_back_to_back;
        int lat;
        hundreds = 2'd0; tens = 4'd0; ones = 4'd0;
        start = 1'b1;
        step;
        for (int v = 0; v < 256; v++) begin
            lat = 0;
            while (done !== 1'b1 && lat < 20) begin
                step;
                lat++;
            end
            vectors++; if (out !== v[7:0] || error !== 1'b0 || lat != 8) begin
                miscompares++;
                $display("FAIL b2b_%0d got out=%0d err=%b lat=%0d want out=%0d err=0 lat=8", v, out, error, lat, v);
            end
            if (v < 255) begin
                hundreds = 2'((v + 1) / 100);
                tens     = 4'(((v + 1) / 10) % 10);
                ones     = 4'((v + 1) % 10);
            end else begin
                start = 1'b0;
            end
            step;
            vectors++; if (done !== 1'b0 || busy !== (v < 255)) begin
                miscompares++;
                $display("FAIL b2b_restart_%0d got done=%b busy=%b want done=0 busy=%b", v, done, busy, v < 255);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hundreds = 2'd0;
        tens = 4'd0;
        ones = 4'd0;
        test_reset;
        test_zero;
        test_values;
        test_invalid;
        test_start_during_shift;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
